// File: rtl/piso_serializer_amisha_pkg.sv
// Shared definitions for the parallel-in/serial-out read side of the 8-bit data register.
package piso_serializer_amisha_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_serializer_amisha.sv
// Accepts one parallel word over a valid/ready handshake and shifts it out on a registered
// serial line, holding each bit CLKS_PER_BIT clocks, framed by sframe and closed by a done pulse.
module piso_serializer_amisha
  import piso_serializer_amisha_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             load_valid_amisha,
  output logic             load_ready_amisha,
  input  logic [WIDTH-1:0] d_amisha,
  output logic             sdata_amisha,
  output logic             sframe_amisha,
  output logic             done_amisha
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sdata_d, sframe_d, done_d;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready depends on state alone so there is no combinational path from load_valid.
  assign load_ready_amisha = (state_q == ST_IDLE);
  assign accept            = load_valid_amisha & load_ready_amisha;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          shreg_d   = d_amisha;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = ST_IDLE;
            shreg_d   = '0;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            shreg_d   = shift_once(shreg_q);
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state values so the first bit shows the cycle after accept.
    sframe_d = (state_d == ST_SHIFT);
    sdata_d  = sframe_d & head_bit(shreg_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      sdata_amisha  <= 1'b0;
      sframe_amisha <= 1'b0;
      done_amisha   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      sdata_amisha  <= sdata_d;
      sframe_amisha <= sframe_d;
      done_amisha   <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer_amisha.sv
// Bench for piso_serializer_amisha: two instances (MSB-first/4 clocks, LSB-first/1 clock)
// checked against a bit-stream model derived from the word, bit order and hold time.
module tb_piso_serializer_amisha;

  logic       clk_amisha = 1'b0;
  logic       reset_amisha;
  logic       load_valid [2];
  logic [7:0] d          [2];
  logic       ready      [2];
  logic       sdata      [2];
  logic       sframe     [2];
  logic       done       [2];

  int passed = 0;
  int total  = 0;

  always #5 clk_amisha = ~clk_amisha;

  piso_serializer_amisha #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1)) dut_a (
    .clk_amisha       (clk_amisha),
    .reset_amisha     (reset_amisha),
    .load_valid_amisha(load_valid[0]),
    .load_ready_amisha(ready[0]),
    .d_amisha         (d[0]),
    .sdata_amisha     (sdata[0]),
    .sframe_amisha    (sframe[0]),
    .done_amisha      (done[0])
  );

  piso_serializer_amisha #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(0)) dut_b (
    .clk_amisha       (clk_amisha),
    .reset_amisha     (reset_amisha),
    .load_valid_amisha(load_valid[1]),
    .load_ready_amisha(ready[1]),
    .d_amisha         (d[1]),
    .sdata_amisha     (sdata[1]),
    .sframe_amisha    (sframe[1]),
    .done_amisha      (done[1])
  );

  // Reference model: hold time and bit order of each instance.
  function automatic int cpb(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic exp_bit(input int k, input logic [7:0] w, input int i);
    return (k == 0) ? w[7-i] : w[i];
  endfunction

  // Called at a negedge: waits (bounded) for ready, then presents the word.
  task automatic load_word(input int k, input logic [7:0] w, input string name);
    int n = 0;
    while (ready[k] !== 1'b1 && n < 200) begin
      @(negedge clk_amisha);
      n++;
    end
    total++;
    if (ready[k] !== 1'b1) $display("FAIL %s ready_wait: ready=%b, expected 1", name, ready[k]);
    else passed++;
    load_valid[k] = 1'b1;
    d[k]          = w;
  endtask

  // Observes one frame after an accept and ends at the negedge of the done cycle.
  task automatic run_frame(input int k, input logic [7:0] w, input bit hold_next,
                           input logic [7:0] next_w, input bit poke, input string name);
    int n = 8 * cpb(k);
    @(negedge clk_amisha);
    for (int c = 0; c < n; c++) begin
      logic eb;
      eb = exp_bit(k, w, c / cpb(k));
      total++;
      if (sframe[k] !== 1'b1 || sdata[k] !== eb || ready[k] !== 1'b0 || done[k] !== 1'b0)
        $display("FAIL %s cycle %0d: sframe=%b sdata=%b ready=%b done=%b, expected 1 %b 0 0",
                 name, c, sframe[k], sdata[k], ready[k], done[k], eb);
      else passed++;
      if (c == 0) begin
        load_valid[k] = hold_next;
        d[k]          = hold_next ? next_w : w;
      end
      if (poke && c == n / 2) d[k] = 8'h3C;
      @(negedge clk_amisha);
    end
    total++;
    if (sframe[k] !== 1'b0 || done[k] !== 1'b1 || ready[k] !== 1'b1 || sdata[k] !== 1'b0)
      $display("FAIL %s done_cycle: sframe=%b done=%b ready=%b sdata=%b, expected 0 1 1 0",
               name, sframe[k], done[k], ready[k], sdata[k]);
    else passed++;
  endtask

  task automatic test_reset();
    reset_amisha = 1'b1;
    repeat (3) @(posedge clk_amisha);
    @(negedge clk_amisha);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ready[k] !== 1'b1 || sdata[k] !== 1'b0 || sframe[k] !== 1'b0 || done[k] !== 1'b0)
        $display("FAIL reset[%0d]: ready=%b sdata=%b sframe=%b done=%b, expected 1 0 0 0",
                 k, ready[k], sdata[k], sframe[k], done[k]);
      else passed++;
    end
    reset_amisha = 1'b0;
    @(negedge clk_amisha);
  endtask

  task automatic test_msb_cpb4();
    load_word(0, 8'hA5, "msb_a5");
    run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0, "msb_a5");
    @(negedge clk_amisha);
  endtask

  task automatic test_lsb_cpb1();
    load_word(1, 8'h01, "lsb_01");
    run_frame(1, 8'h01, 1'b0, 8'h00, 1'b0, "lsb_01");
    @(negedge clk_amisha);
  endtask

  task automatic test_back_to_back();
    load_word(0, 8'hFF, "b2b_ff");
    run_frame(0, 8'hFF, 1'b1, 8'h00, 1'b0, "b2b_ff");
    run_frame(0, 8'h00, 1'b0, 8'h00, 1'b0, "b2b_00");
    @(negedge clk_amisha);
  endtask

  task automatic test_busy_ignore();
    load_word(0, 8'hC3, "busy_c3");
    run_frame(0, 8'hC3, 1'b0, 8'h00, 1'b1, "busy_c3");
    @(negedge clk_amisha);
  endtask

  task automatic test_reset_mid_frame();
    int seen_done = 0;
    load_word(0, 8'h5A, "rst_5a");
    @(negedge clk_amisha);
    load_valid[0] = 1'b0;
    repeat (12) @(negedge clk_amisha);
    total++;
    if (sframe[0] !== 1'b1 || sdata[0] !== exp_bit(0, 8'h5A, 3))
      $display("FAIL rst_bit3: sframe=%b sdata=%b, expected 1 %b",
               sframe[0], sdata[0], exp_bit(0, 8'h5A, 3));
    else passed++;
    reset_amisha = 1'b1;
    @(negedge clk_amisha);
    total++;
    if (sframe[0] !== 1'b0 || sdata[0] !== 1'b0 || ready[0] !== 1'b1 || done[0] !== 1'b0)
      $display("FAIL rst_abort: sframe=%b sdata=%b ready=%b done=%b, expected 0 0 1 0",
               sframe[0], sdata[0], ready[0], done[0]);
    else passed++;
    // Reset wins over a simultaneous load request.
    load_valid[0] = 1'b1;
    d[0]          = 8'h81;
    @(negedge clk_amisha);
    total++;
    if (sframe[0] !== 1'b0 || ready[0] !== 1'b1)
      $display("FAIL rst_vs_valid: sframe=%b ready=%b, expected 0 1", sframe[0], ready[0]);
    else passed++;
    load_valid[0] = 1'b0;
    reset_amisha  = 1'b0;
    repeat (40) begin
      @(negedge clk_amisha);
      if (done[0] !== 1'b0 || sframe[0] !== 1'b0) seen_done++;
    end
    total++;
    if (seen_done != 0)
      $display("FAIL rst_no_done: activity cycles=%0d, expected 0", seen_done);
    else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] w;
      w = 8'($urandom);
      load_word(k, w, "rand_load");
      for (int j = 0; j < 10; j++) begin
        logic [7:0] nw;
        bit         hold;
        nw   = 8'($urandom);
        hold = (j < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
        run_frame(k, w, hold, nw, 1'b0, "rand_frame");
        if (!hold && j < 9) begin
          int gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) begin
            @(negedge clk_amisha);
            total++;
            if (done[k] !== 1'b0 || sframe[k] !== 1'b0)
              $display("FAIL rand_gap: done=%b sframe=%b, expected 0 0", done[k], sframe[k]);
            else passed++;
          end
          load_word(k, nw, "rand_load");
        end
        w = nw;
      end
      @(negedge clk_amisha);
    end
  endtask

  initial begin
    reset_amisha = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_valid[k] = 1'b0;
      d[k]          = 8'h00;
    end
    @(negedge clk_amisha);
    test_reset();
    test_msb_cpb4();
    test_lsb_cpb1();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
